// File: rtl/zero_skip_pkg.sv
// Shared types and helpers for the zero-skipping row compressor.
package zero_skip_pkg;

    typedef enum logic {StIdle, StDrain} state_e;

    // Widest mask the popcount helper handles; callers zero-extend into it.
    localparam int unsigned MaxRowSize = 64;

    function automatic logic pop_is_one(input logic [MaxRowSize-1:0] mask);
        return (mask != '0) && ((mask & (mask - MaxRowSize'(1))) == '0);
    endfunction

endpackage

// File: rtl/lowest_one_encoder.sv
// Priority encoder: index of the lowest set bit of mask, plus an any-set flag.
module lowest_one_encoder #(
    parameter int unsigned MAX_R_SIZE  = 8,
    parameter int unsigned R_IDX_WIDTH = 3
) (
    input  logic [MAX_R_SIZE-1:0]  mask,
    output logic [R_IDX_WIDTH-1:0] sel,
    output logic                   any
);

    always_comb begin
        sel = '0;
        any = 1'b0;
        // Scan downwards so the lowest set bit is the last to write sel.
        for (int i = MAX_R_SIZE - 1; i >= 0; i--) begin
            if (mask[i]) begin
                sel = R_IDX_WIDTH'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/zero_skip_compressor.sv
// Streaming zero-skipping row compressor: one row in, one beat per non-zero word out.
// Optional macro ZERO_SKIP_IDX_EN adds the idx_out port carrying each word's original index.
module zero_skip_compressor
    import zero_skip_pkg::*;
#(
    parameter int unsigned WORD_WIDTH  = 8,
    parameter int unsigned MAX_R_SIZE  = 8,
    parameter int unsigned R_IDX_WIDTH = 3
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WORD_WIDTH*MAX_R_SIZE-1:0] data_in,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WORD_WIDTH-1:0]          data_out,
    output logic                           last_out,
    output logic                           empty_out
`ifdef ZERO_SKIP_IDX_EN
    ,
    output logic [R_IDX_WIDTH-1:0]         idx_out
`endif
);

    if (R_IDX_WIDTH != $clog2(MAX_R_SIZE)) begin : g_bad_idx_width
        $error("R_IDX_WIDTH must equal $clog2(MAX_R_SIZE)");
    end
    if (MAX_R_SIZE < 2 || MAX_R_SIZE > MaxRowSize) begin : g_bad_row_size
        $error("MAX_R_SIZE out of supported range");
    end

    state_e                                 state_q, state_d;
    logic [MAX_R_SIZE-1:0][WORD_WIDTH-1:0]  row_q, row_d;
    logic [MAX_R_SIZE-1:0]                  mask_q, mask_d, new_mask;
    logic                                   empty_q, empty_d;
    logic [R_IDX_WIDTH-1:0]                 sel;
    logic                                   any;
    logic                                   draining;
    logic                                   accept;

    lowest_one_encoder #(
        .MAX_R_SIZE  (MAX_R_SIZE),
        .R_IDX_WIDTH (R_IDX_WIDTH)
    ) u_lowest_one (
        .mask (mask_q),
        .sel  (sel),
        .any  (any)
    );

    assign draining  = (state_q == StDrain);
    assign out_valid = draining;
    assign data_out  = any ? row_q[sel] : '0;
    assign empty_out = draining && empty_q;
    assign last_out  = draining && (pop_is_one(MaxRowSize'(mask_q)) || empty_q);
    assign in_ready  = !draining || (out_ready && last_out);
    assign accept    = in_valid && in_ready;
`ifdef ZERO_SKIP_IDX_EN
    assign idx_out   = sel;
`endif

    always_comb begin
        new_mask = '0;
        for (int i = 0; i < MAX_R_SIZE; i++) begin
            new_mask[i] = |data_in[WORD_WIDTH*i +: WORD_WIDTH];
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        mask_d  = mask_q;
        empty_d = empty_q;
        if (draining && out_ready) begin
            if (any) begin
                mask_d[sel] = 1'b0;
            end
            if (last_out) begin
                state_d = StIdle;
            end
        end
        // A row accepted on the final beat overrides the return to idle.
        if (accept) begin
            row_d   = data_in;
            mask_d  = new_mask;
            empty_d = (new_mask == '0);
            state_d = StDrain;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            row_q   <= '0;
            mask_q  <= '0;
            empty_q <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            mask_q  <= mask_d;
            empty_q <= empty_d;
        end
    end

endmodule

// File: tb/tb_zero_skip_compressor.sv
// Self-checking bench for zero_skip_compressor (WORD_WIDTH=8, MAX_R_SIZE=4).
module tb_zero_skip_compressor;

    typedef struct {
        logic [7:0] data;
        logic [1:0] idx;
        logic       last;
        logic       empty;
    } beat_t;

    typedef struct {
        logic [7:0] data;
        logic [1:0] idx;
        logic       last;
        logic       empty;
        logic       ir;
        int         cyc;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] data_in;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  data_out;
    logic        last_out;
    logic        empty_out;
    logic [1:0]  idx_out;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    beat_t exp_q[$];
    obs_t  log_q[$];

    zero_skip_compressor #(
        .WORD_WIDTH  (8),
        .MAX_R_SIZE  (4),
        .R_IDX_WIDTH (2)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .last_out  (last_out),
        .empty_out (empty_out)
`ifdef ZERO_SKIP_IDX_EN
        ,
        .idx_out   (idx_out)
`endif
    );

`ifndef ZERO_SKIP_IDX_EN
    assign idx_out = 2'd0;
`endif

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Model: a row becomes its list of non-zero words, or a single empty beat.
    function automatic void push_row(input logic [31:0] row);
        int n = 0;
        for (int i = 0; i < 4; i++) begin
            logic [7:0] w = row[8*i +: 8];
            if (w != 8'h00) begin
                exp_q.push_back('{data: w, idx: 2'(i), last: 1'b0, empty: 1'b0});
                n++;
            end
        end
        if (n == 0) exp_q.push_back('{data: 8'h00, idx: 2'd0, last: 1'b1, empty: 1'b1});
        else        exp_q[exp_q.size()-1].last = 1'b1;
    endfunction

    function automatic logic model_in_ready();
        return (exp_q.size() == 0) || (out_ready && exp_q[0].last);
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (reset_n) begin
            logic acc;
            acc = in_valid && model_in_ready();
            if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
            if (acc) push_row(data_in);
        end
    end

    // Compare process: outputs are checked every cycle against the model.
    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
            chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
            chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        end else begin
            chk("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
            chk("in_ready", {31'd0, in_ready}, {31'd0, model_in_ready()});
            if (exp_q.size() != 0) begin
                chk("data_out", {24'd0, data_out}, {24'd0, exp_q[0].data});
                chk("last_out", {31'd0, last_out}, {31'd0, exp_q[0].last});
                chk("empty_out", {31'd0, empty_out}, {31'd0, exp_q[0].empty});
`ifdef ZERO_SKIP_IDX_EN
                chk("idx_out", {30'd0, idx_out}, {30'd0, exp_q[0].idx});
`endif
            end
            if (out_valid && out_ready)
                log_q.push_back('{data: data_out, idx: idx_out, last: last_out,
                                  empty: empty_out, ir: in_ready, cyc: cyc});
        end
    end

    task automatic send_row(input logic [31:0] row);
        logic done = 1'b0;
        in_valid = 1'b1;
        data_in  = row;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        if (!done) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_drained();
        logic done = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) done = 1'b1;
        end
        if (!done) chk("drain_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_log(input int k, input logic [7:0] d, input logic [1:0] ix,
                           input logic l, input logic e);
        if (k >= log_q.size()) begin
            chk("log_missing", k, log_q.size());
        end else begin
            chk($sformatf("lit_data[%0d]", k), {24'd0, log_q[k].data}, {24'd0, d});
            chk($sformatf("lit_last[%0d]", k), {31'd0, log_q[k].last}, {31'd0, l});
            chk($sformatf("lit_empty[%0d]", k), {31'd0, log_q[k].empty}, {31'd0, e});
`ifdef ZERO_SKIP_IDX_EN
            chk($sformatf("lit_idx[%0d]", k), {30'd0, log_q[k].idx}, {30'd0, ix});
`else
            if (ix != ix) chk("unused", 32'd0, 32'd0);
`endif
        end
    endtask

    task automatic chk_consec(input int k);
        if (k + 1 < log_q.size())
            chk($sformatf("no_bubble[%0d]", k), log_q[k+1].cyc, log_q[k].cyc + 1);
        else
            chk("log_missing", k + 1, log_q.size());
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        data_in   = '0;
        @(negedge clk);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_data_out", {24'd0, data_out}, 32'd0);
        chk("reset_last_out", {31'd0, last_out}, 32'd0);
        chk("reset_empty_out", {31'd0, empty_out}, 32'd0);
        chk("reset_idx_out", {30'd0, idx_out}, 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Sparse row {00,05,00,09}.
        send_row(32'h09_00_05_00);
        wait_drained();

        // Empty row followed immediately by another row.
        send_row(32'h00_00_00_00);
        send_row(32'h00_0A_00_00);
        wait_drained();

        // Full row under back-pressure.
        out_ready = 1'b0;
        send_row(32'h04_03_02_01);
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
        wait_drained();

        // Back-to-back single-word rows.
        send_row(32'h00_00_00_07);
        send_row(32'h08_00_00_00);
        wait_drained();

        // Reset during the second beat discards the row.
        send_row(32'h44_33_22_11);
        @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        send_row(32'h00_55_00_00);
        wait_drained();

        chk_log(0, 8'h05, 2'd1, 1'b0, 1'b0);
        chk_log(1, 8'h09, 2'd3, 1'b1, 1'b0);
        if (log_q.size() > 1) chk("s1_in_ready_beat2", {31'd0, log_q[1].ir}, 32'd1);
        chk_log(2, 8'h00, 2'd0, 1'b1, 1'b1);
        chk_log(3, 8'h0A, 2'd2, 1'b1, 1'b0);
        chk_consec(2);
        chk_log(4, 8'h01, 2'd0, 1'b0, 1'b0);
        chk_log(5, 8'h02, 2'd1, 1'b0, 1'b0);
        chk_log(6, 8'h03, 2'd2, 1'b0, 1'b0);
        chk_log(7, 8'h04, 2'd3, 1'b1, 1'b0);
        chk_consec(4);
        chk_consec(5);
        chk_consec(6);
        chk_log(8, 8'h07, 2'd0, 1'b1, 1'b0);
        chk_log(9, 8'h08, 2'd3, 1'b1, 1'b0);
        chk_consec(8);
        chk_log(10, 8'h11, 2'd0, 1'b0, 1'b0);
        chk_log(11, 8'h55, 2'd2, 1'b1, 1'b0);
        chk("beat_count", log_q.size(), 32'd12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
